// File: rtl/data_break_arbiter_if.sv
// data_break_arbiter_if: requester-side and CPU-side break signals of the data-break arbiter
interface data_break_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 15
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_to_disk;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*12-1:0] req_wdata;
    logic [NREQ-1:0]    ack;
    logic [11:0]        rd_data;
    logic               break_in_prog;
    logic [11:0]        mem_rdata;
    logic               data_break;
    logic               to_disk;
    logic [AW-1:0]      db_addr;
    logic [11:0]        db_wdata;
    logic               busy;

    modport slave (
        input  req, req_to_disk, req_addr, req_wdata, break_in_prog, mem_rdata,
        output ack, rd_data, data_break, to_disk, db_addr, db_wdata, busy
    );

    modport master (
        output req, req_to_disk, req_addr, req_wdata, break_in_prog, mem_rdata,
        input  ack, rd_data, data_break, to_disk, db_addr, db_wdata, busy
    );
endinterface

// File: rtl/data_break_arbiter.sv
// data_break_arbiter: round-robin sharing of the CPU data-break channel among NREQ requesters
module data_break_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 15
) (
    input logic               clk,
    input logic               reset,
    data_break_arbiter_if.slave bus
);
    localparam int WW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   ptr_q, ptr_d;
    logic [WW-1:0]   winner_q, winner_d;
    logic            to_disk_q, to_disk_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [11:0]     wdata_q, wdata_d;
    logic            data_break_q, data_break_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [11:0]     rd_data_q, rd_data_d;
    logic [11:0]     cap_q, cap_d;
    logic [WW-1:0]   win;
    logic [WW-1:0]   idx;
    logic            hit;

    // first requester at or above ptr, wrapping past NREQ-1 back to 0
    always_comb begin
        win = ptr_q;
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = WW'((int'(ptr_q) + i) % NREQ);
            if (!hit && bus.req[idx]) begin
                hit = 1'b1;
                win = idx;
            end
        end
    end

    // next state: grant, wait for DB0, capture read data, then one-cycle ack
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        winner_d     = winner_q;
        to_disk_d    = to_disk_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        data_break_d = data_break_q;
        ack_d        = '0;
        rd_data_d    = rd_data_q;
        cap_d        = cap_q;
        case (state_q)
            IDLE: if (hit && !bus.break_in_prog) begin
                state_d      = REQ;
                winner_d     = win;
                to_disk_d    = bus.req_to_disk[win];
                addr_d       = bus.req_addr[win*AW +: AW];
                wdata_d      = bus.req_wdata[win*12 +: 12];
                data_break_d = 1'b1;
            end
            REQ: if (bus.break_in_prog) begin
                data_break_d = 1'b0;
                state_d      = XFER;
            end
            XFER: if (bus.break_in_prog) begin
                cap_d = bus.mem_rdata;
            end else begin
                state_d   = DONE;
                ack_d     = ONE << winner_q;
                rd_data_d = cap_q;
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = (winner_q == WW'(NREQ - 1)) ? '0 : winner_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and latched break fields; reset abandons any break without an ack
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            winner_q     <= '0;
            to_disk_q    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            data_break_q <= 1'b0;
            ack_q        <= '0;
            rd_data_q    <= '0;
            cap_q        <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            winner_q     <= winner_d;
            to_disk_q    <= to_disk_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            data_break_q <= data_break_d;
            ack_q        <= ack_d;
            rd_data_q    <= rd_data_d;
            cap_q        <= cap_d;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.data_break = data_break_q;
    assign bus.to_disk    = to_disk_q;
    assign bus.db_addr    = addr_q;
    assign bus.db_wdata   = wdata_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_data_break_arbiter.sv
// tb_data_break_arbiter: directed and randomized checks of the data-break arbiter against a round-robin model
module tb_data_break_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 15;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   ptr_m = 0;

    logic [AW-1:0] addr_a [NREQ];
    logic [11:0]   wdata_a[NREQ];
    logic          td_a   [NREQ];

    data_break_arbiter_if #(.NREQ(NREQ), .AW(AW)) bif ();

    data_break_arbiter #(.NREQ(NREQ), .AW(AW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif.slave)
    );

    always #5 clk = ~clk;

    // flatten per-requester bench arrays onto the bus
    always_comb begin
        bif.req_addr    = '0;
        bif.req_wdata   = '0;
        bif.req_to_disk = '0;
        for (int i = 0; i < NREQ; i++) begin
            bif.req_addr[i*AW +: AW]  = addr_a[i];
            bif.req_wdata[i*12 +: 12] = wdata_a[i];
            bif.req_to_disk[i]        = td_a[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // round-robin rule: first pending requester at or after the pointer
    function automatic int pick(input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++)
            if (r[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
        return -1;
    endfunction

    // one complete break; caller has set req at a negedge while the arbiter is idle
    task automatic serve(input int dbc, input int stall, input int fixed_mem, input bit clr,
                         input bit scramble, output int w, output int lat);
        logic [AW-1:0] ea;
        logic [11:0]   ew;
        logic [11:0]   last;
        logic          et;
        int            bad;
        lat = 0;
        last = '0;
        do begin
            @(negedge clk);
            lat++;
        end while (bif.data_break !== 1'b1 && lat < 50);
        chk("grant", 32'(bif.data_break), 32'd1);
        w = pick(bif.req);
        if (w < 0) begin
            chk("pending_req", 32'(bif.req), 32'd1);
            w = 0;
        end
        ea = addr_a[w];
        ew = wdata_a[w];
        et = td_a[w];
        chk("db_addr", 32'(bif.db_addr), 32'(ea));
        chk("db_wdata", 32'(bif.db_wdata), 32'(ew));
        chk("to_disk", 32'(bif.to_disk), 32'(et));
        chk("busy_grant", 32'(bif.busy), 32'd1);
        if (scramble) begin
            for (int i = 0; i < NREQ; i++) begin
                addr_a[i]  = AW'($urandom);
                wdata_a[i] = 12'($urandom);
                td_a[i]    = 1'($urandom);
            end
            bif.req[w] = 1'b0;
        end
        bad = 0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (bif.data_break !== 1'b1 || bif.busy !== 1'b1 || bif.ack !== '0) bad++;
        end
        if (stall > 0) chk("stall_cycles_bad", 32'(bad), 32'd0);
        for (int i = 0; i < dbc; i++) begin
            last = (fixed_mem >= 0) ? 12'(fixed_mem) : 12'($urandom);
            bif.mem_rdata     = last;
            bif.break_in_prog = 1'b1;
            @(negedge clk);
            if (i == 0) chk("data_break_drop", 32'(bif.data_break), 32'd0);
        end
        bif.break_in_prog = 1'b0;
        bif.mem_rdata     = 12'($urandom);
        @(negedge clk);
        chk("ack", 32'(bif.ack), 32'(1 << w));
        chk("rd_data", 32'(bif.rd_data), 32'(last));
        chk("db_addr_held", 32'(bif.db_addr), 32'(ea));
        chk("db_wdata_held", 32'(bif.db_wdata), 32'(ew));
        chk("to_disk_held", 32'(bif.to_disk), 32'(et));
        ptr_m = (w + 1) % NREQ;
        if (clr) bif.req[w] = 1'b0;
        @(negedge clk);
        chk("ack_single", 32'(bif.ack), 32'd0);
        chk("rd_data_hold", 32'(bif.rd_data), 32'(last));
        chk("idle_gap", 32'(bif.data_break), 32'd0);
        chk("busy_idle", 32'(bif.busy), 32'd0);
    endtask

    initial begin
        int w;
        int lat;
        int bad;
        int order[5] = '{0, 1, 2, 3, 0};
        bif.req           = '0;
        bif.break_in_prog = 1'b0;
        bif.mem_rdata     = '0;
        for (int i = 0; i < NREQ; i++) begin
            addr_a[i]  = AW'(16'o1000 * (i + 1) + i);
            wdata_a[i] = 12'(12'o100 * (i + 1));
            td_a[i]    = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_data_break", 32'(bif.data_break), 32'd0);
        chk("rst_busy", 32'(bif.busy), 32'd0);
        chk("rst_ack", 32'(bif.ack), 32'd0);
        chk("rst_rd_data", 32'(bif.rd_data), 32'd0);
        chk("rst_db_addr", 32'(bif.db_addr), 32'd0);
        chk("rst_db_wdata", 32'(bif.db_wdata), 32'd0);
        chk("rst_to_disk", 32'(bif.to_disk), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // round robin with all four held
        bif.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            serve(2 + k % 2, 0, -1, 1'b0, 1'b0, w, lat);
            chk("rr_order", 32'(w), 32'(order[k]));
        end
        bif.req = '0;

        // single write request from requester 1
        addr_a[1]  = 15'o01234;
        wdata_a[1] = 12'o7654;
        td_a[1]    = 1'b0;
        bif.req    = 4'b0010;
        serve(3, 0, -1, 1'b1, 1'b0, w, lat);
        chk("single_winner", 32'(w), 32'd1);
        chk("single_latency", 32'(lat), 32'd1);

        // wrap: grant 2 leaves ptr at 3, then 0 before 2
        bif.req = 4'b0100;
        serve(2, 0, -1, 1'b1, 1'b0, w, lat);
        chk("wrap_first", 32'(w), 32'd2);
        bif.req = 4'b0101;
        serve(2, 0, -1, 1'b1, 1'b0, w, lat);
        chk("wrap_second", 32'(w), 32'd0);
        serve(2, 0, -1, 1'b1, 1'b0, w, lat);
        chk("wrap_third", 32'(w), 32'd2);

        // read break returns mem data
        td_a[0] = 1'b1;
        bif.req = 4'b0001;
        serve(3, 0, 12'o0017, 1'b1, 1'b0, w, lat);
        chk("read_winner", 32'(w), 32'd0);
        chk("read_rd_data", 32'(bif.rd_data), 32'o0017);

        // CPU halted: request waits 500 cycles
        bif.req = 4'b1000;
        serve(3, 500, -1, 1'b1, 1'b0, w, lat);
        chk("stall_winner", 32'(w), 32'd3);

        // unowned break while idle blocks the grant until it falls
        bif.break_in_prog = 1'b1;
        bif.req = 4'b0001;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bif.data_break !== 1'b0 || bif.busy !== 1'b0) bad++;
        end
        chk("unowned_no_grant", 32'(bad), 32'd0);
        bif.break_in_prog = 1'b0;
        serve(2, 0, -1, 1'b1, 1'b0, w, lat);
        chk("unowned_after", 32'(w), 32'd0);

        // randomized traffic, sometimes scrambling inputs and dropping req after grant
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                addr_a[i]  = AW'($urandom);
                wdata_a[i] = 12'($urandom);
                td_a[i]    = 1'($urandom);
            end
            bif.req = NREQ'($urandom_range(1, 15));
            serve(int'($urandom_range(2, 5)), int'($urandom_range(0, 3)), -1, 1'b1,
                  1'($urandom), w, lat);
            bif.req = '0;
        end

        // reset during XFER aborts without ack, then a fresh grant to 0
        bif.req = 4'b0011;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bif.data_break !== 1'b1 && lat < 50);
        chk("pre_reset_grant", 32'(bif.data_break), 32'd1);
        bif.break_in_prog = 1'b1;
        bif.mem_rdata     = 12'o5555;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("arst_busy", 32'(bif.busy), 32'd0);
        chk("arst_ack", 32'(bif.ack), 32'd0);
        chk("arst_rd_data", 32'(bif.rd_data), 32'd0);
        chk("arst_db_addr", 32'(bif.db_addr), 32'd0);
        chk("arst_db_wdata", 32'(bif.db_wdata), 32'd0);
        chk("arst_to_disk", 32'(bif.to_disk), 32'd0);
        chk("arst_data_break", 32'(bif.data_break), 32'd0);
        bif.break_in_prog = 1'b0;
        @(negedge clk);
        chk("arst_no_ack", 32'(bif.ack), 32'd0);
        reset = 1'b1;
        ptr_m = 0;
        serve(2, 0, -1, 1'b1, 1'b0, w, lat);
        chk("post_reset_winner", 32'(w), 32'd0);
        bif.req = '0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_break_arbiter.md
Name: data_break_arbiter

Overview:
- Shares the CPU's single data-break (DMA) channel among up to NREQ peripheral requesters, e.g. the RK8E disk and a future TC08 tape.
- Grants requesters round-robin and drives the state machine's data_break/to_disk inputs.
- Tracks break_in_prog to sequence one DB0-DB2 break per grant, presenting the winner's address and write data to the memory path.
- Returns read data and a completion ack to the winner.

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 15, break address width: 3-bit field plus 12-bit word address, bit 0 is MSB.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester break request; level, held until ack.
- req_to_disk  input  NREQ  per-requester direction: 1 = memory read (data to device), 0 = memory write.
- req_addr  input  NREQ*AW  flattened per-requester break address.
- req_wdata  input  NREQ*12  flattened per-requester write data.
- ack  output  NREQ  one-cycle completion pulse to the winner.
- rd_data  output  12  memory read data; valid in the ack cycle, held until the next ack.
- break_in_prog  input  1  from state machine; high during DB0..DB2.
- mem_rdata  input  12  memory read data during a break.
- data_break  output  1  break request to state machine.
- to_disk  output  1  direction of the current break.
- db_addr  output  AW  address of the current break.
- db_wdata  output  12  write data of the current break.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (reset low, async): state IDLE, ptr=0, data_break=0, to_disk=0, db_addr=0, db_wdata=0, ack=0, rd_data=0, busy=0, winner=0.
- States: IDLE, REQ, XFER, DONE.
- IDLE:
  - If any req bit is set, choose the winner as the first set bit searching upward from ptr, wrapping at NREQ-1 to 0.
  - Latch the winner index, to_disk, db_addr and db_wdata from that requester's slices.
  - Set data_break=1 and go to REQ. Latching and data_break assertion occur on the same edge.
- REQ:
  - Hold data_break=1 until break_in_prog is sampled 1, then clear data_break and go to XFER.
  - The state machine samples data_break only in F3/D3/E3. Dropping it at DB0 entry therefore guarantees exactly one break per grant.
  - REQ waits indefinitely, e.g. while the CPU is in H0..H3. There is no timeout.
- XFER:
  - While break_in_prog=1, register mem_rdata every cycle into an internal capture register.
  - When break_in_prog is sampled 0, go to DONE.
- DONE (one cycle):
  - Pulse ack[winner]=1.
  - Drive rd_data from the capture register, i.e. mem_rdata from the last DB cycle.
  - Set ptr = winner+1 mod NREQ and return to IDLE.
  - The earliest next grant is the following cycle. Minimum spacing between data_break assertions is 1 idle cycle.
- Latched fields (to_disk, db_addr, db_wdata, winner) are stable from the grant edge through DONE. Requester inputs changing after grant are ignored.
- A req dropped after grant does not abort the break; the break completes and ack still pulses.
- A req dropped before grant is never serviced.
- Requesters must deassert req in the cycle after ack, otherwise they are eligible again. Round-robin keeps a single requester from starving the others.
- With a single requester, back-to-back breaks occur with the IDLE gap.
- break_in_prog seen high while IDLE is an unowned break: ignore it and do not grant until it falls.
- Reset asserted mid-break returns to IDLE immediately. No ack is issued.
- Width rules: the winner field is ceil(log2 NREQ) bits. ptr wraps modulo NREQ for non-power-of-two NREQ.

Test Plan:
1. Single request: req=4'b0010, addr=15'o01234, wdata=12'o7654, req_to_disk=0.
   - Required: data_break rises next edge with db_addr=01234, db_wdata=7654, to_disk=0.
   - Drive break_in_prog high for 3 cycles. data_break falls one cycle after break_in_prog rises.
   - ack=4'b0010 one cycle after break_in_prog falls.
2. Read break: req[0], req_to_disk=1; mem_rdata=12'o0017 during the 3 DB cycles.
   - Required: rd_data=0017 with ack[0]=1.
3. Round-robin: req=4'b1111 held, each break serviced.
   - Required: ack order 0,1,2,3,0. No grant repeats until the others have been served.
4. Wrap: ptr=3 after a grant to 2, then req=4'b0101.
   - Required: next grant to 0 (wrap from 3), then to 2.
5. Stall: hold break_in_prog=0 for 500 cycles after the request (CPU halted).
   - Required: data_break stays 1, busy=1, no ack.
   - Then complete the break: exactly one ack.
6. Reset low during XFER.
   - Required: all outputs 0 asynchronously, no ack.
   - After reset release with req still set, a fresh grant to requester 0.
